// File: rtl/alu_nibble_seq.sv
// Sequential W-bit ALU that reuses one external 4-bit combinational slice ALU, LSB nibble first.
// Optional overflow output is enabled with macro ALU_SEQ_OVF_EN.
module alu_nibble_seq #(
  parameter int NSLICE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*NSLICE-1:0]   x,
  input  logic [4*NSLICE-1:0]   y,
  input  logic [5:0]            ctrl,
  output logic                  busy,
  output logic                  done,
  output logic [4*NSLICE-1:0]   out,
  output logic                  zr,
  output logic                  ng,
`ifdef ALU_SEQ_OVF_EN
  output logic                  ovf,
`endif
  output logic [3:0]            alu_x,
  output logic [3:0]            alu_y,
  output logic [5:0]            alu_ctrl,
  output logic                  alu_cin,
  input  logic [3:0]            alu_out,
  input  logic                  alu_cout
);

  localparam int W  = 4 * NSLICE;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_run;
  logic            w_accept;
  logic            w_last;

  logic [W-1:0]    r_x;
  logic [W-1:0]    r_y;
  logic [5:0]      r_ctrl;
  logic [KW-1:0]   r_k;
  logic            r_carry;
  logic [W-1:0]    r_result;
  logic [W-1:0]    w_result_next;
  logic [W-1:0]    r_out;
  logic            r_zr;
  logic            r_ng;

  assign w_last = (r_k == KW'(NSLICE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_run        = 1'b0;
    w_accept     = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_run = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Current slice result merged into the partial result; on the last slice this is the full answer.
  always_comb begin
    w_result_next = r_result;
    w_result_next[4*r_k +: 4] = alu_out;
  end

`ifdef ALU_SEQ_OVF_EN
  logic w_ex;
  logic w_ey;
  logic w_r;
  logic w_ovf_next;
  logic r_ovf;

  // Signed overflow of the adder: both effective operands share a sign the (pre-no) result lacks.
  assign w_ex       = (r_ctrl[5] ? 1'b0 : r_x[W-1]) ^ r_ctrl[4];
  assign w_ey       = (r_ctrl[3] ? 1'b0 : r_y[W-1]) ^ r_ctrl[2];
  assign w_r        = w_result_next[W-1] ^ r_ctrl[0];
  assign w_ovf_next = r_ctrl[1] & (w_ex == w_ey) & (w_r != w_ex);
  assign ovf        = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_run && w_last) begin
      r_ovf <= w_ovf_next;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_ctrl   <= '0;
      r_k      <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_out    <= '0;
      r_zr     <= 1'b0;
      r_ng     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x      <= x;
        r_y      <= y;
        r_ctrl   <= ctrl;
        r_k      <= '0;
        r_carry  <= 1'b0;
        r_result <= '0;
      end
      if (w_run) begin
        r_result <= w_result_next;
        // Carry only chains through add; logical AND slices are independent.
        r_carry  <= r_ctrl[1] ? alu_cout : 1'b0;
        if (w_last) begin
          r_out <= w_result_next;
          r_zr  <= (w_result_next == '0);
          r_ng  <= w_result_next[W-1];
        end else begin
          r_k <= r_k + KW'(1);
        end
      end
    end
  end

  assign out      = r_out;
  assign zr       = r_zr;
  assign ng       = r_ng;
  assign alu_x    = w_run ? r_x[4*r_k +: 4] : 4'h0;
  assign alu_y    = w_run ? r_y[4*r_k +: 4] : 4'h0;
  assign alu_ctrl = w_run ? r_ctrl : 6'h00;
  assign alu_cin  = w_run ? r_carry : 1'b0;

endmodule

// File: doc/alu_nibble_seq.md
ALU_NIBBLE_SEQ -- requirements
Module: alu_nibble_seq

Interface
REQ-001 SHALL have parameter NSLICE, default 4: number of 4-bit slices per operation; data width W = 4*NSLICE; legal values 2..8.
REQ-002 SHALL have ports clk (input, 1) and rst (input, 1); one clock; reset is synchronous and active-high.
REQ-003 SHALL have start (input, 1): request pulse; sampled only in IDLE.
REQ-004 SHALL have x, y (input, W each): operands; captured on the accepting edge.
REQ-005 SHALL have ctrl (input, 6): {zx,nx,zy,ny,f,no}; captured on the accepting edge.
REQ-006 SHALL have busy (output, 1): high whenever state is not IDLE.
REQ-007 SHALL have done (output, 1): one-cycle completion pulse.
REQ-008 SHALL have out (output, W): registered result; zr (output, 1): out==0; ng (output, 1): out[W-1].
REQ-009 SHALL have slice ports alu_x, alu_y (output, 4), alu_ctrl (output, 6), alu_cin (output, 1), alu_out (input, 4), alu_cout (input, 1), connecting to one external combinational ALU4.

Function
REQ-010 SHALL implement states IDLE, RUN, DONE: IDLE->RUN on start; RUN->DONE after slice NSLICE-1; DONE->IDLE after one cycle.
REQ-011 SHALL, on the accepting edge, latch x, y and ctrl, set slice index k=0 and clear the carry register.
REQ-012 SHALL, in RUN, drive alu_x = x_reg[4k+3:4k], alu_y = y_reg[4k+3:4k], alu_ctrl = ctrl_reg, and alu_cin = carry register (0 when k=0).
REQ-013 SHALL, on each RUN edge, write alu_out into result bits [4k+3:4k], load the carry register with alu_cout when f=1 and with 0 when f=0, and increment k.
REQ-014 SHALL update out, zr and ng exactly once per operation, on the edge that leaves RUN; they hold until the next completion.
REQ-015 SHALL assert done for exactly the single DONE cycle; latency is start edge to done high = NSLICE+1 edges (5 for default).
REQ-016 SHALL ignore start while busy: no re-latch, no extra done pulse.
REQ-017 SHALL hold alu_x, alu_y, alu_ctrl and alu_cin at 0 in IDLE and DONE.
REQ-018 SHALL keep slices 0..NSLICE-1 in increasing order; k never wraps within one operation.

Reset
REQ-019 SHALL, with rst high at an edge, force state IDLE, k=0, carry=0, busy=0, done=0, out=0, zr=0, ng=0.
REQ-020 SHALL give rst priority over start and over an in-flight operation: a reset in RUN or DONE aborts with no done pulse, and out reads 0 afterwards.

Configuration
REQ-021 SHALL, with macro ALU_SEQ_OVF_EN defined, add output ovf (1 bit), registered with out.
- ex = (zx ? 0 : x[W-1]) ^ nx; ey likewise from zy, ny, y[W-1]; r = out[W-1] ^ no.
- ovf = f & (ex == ey) & (r != ex).
- Reset value of ovf is 0.
REQ-022 SHALL, without ALU_SEQ_OVF_EN, omit the ovf port and its logic entirely; all other behaviour is identical.

Verification
REQ-023 Reset: rst high 2 cycles, start=1 held -> busy=0, done=0, out=0x0000, zr=0, ng=0.
REQ-024 Carry chain: x=0x00FF, y=0x0001, ctrl=000010 -> done high exactly 5 edges after the start edge; out=0x0100, zr=0, ng=0.
REQ-025 Subtract: x=0x0003, y=0x0005, ctrl=010011 -> out=0xFFFE, ng=1, zr=0; constant zero, ctrl=101010 -> out=0x0000, zr=1.
REQ-026 Busy rule: start re-pulsed 2 cycles after acceptance with x=0x1111 -> ignored; single done pulse; out reflects the first operands only.
REQ-027 Reset mid-op: rst high while k=2 -> busy=0 next cycle, no done pulse, out=0x0000; a new start then completes normally.
REQ-028 With ALU_SEQ_OVF_EN: x=0x7FFF, y=0x0001, ctrl=000010 -> out=0x8000, ovf=1; x=0x0001, y=0x0001 -> ovf=0; without the macro, the bench confirms ovf is absent.
